// File: rtl/fc_layer_stream_pkg.sv
// Shared types and helpers for the streaming fully-connected layer.
package fc_pkg;

   typedef enum logic [2:0] {IDLE, LOAD, MAC, DRAIN, OUT, DONE} fc_state_e;

   // Address widths never collapse to zero bits, so single-entry memories still get a port.
   function automatic int clog2_min1(input int n);
      return (n < 2) ? 1 : $clog2(n);
   endfunction

   localparam int FC_N_IN     = 676;
   localparam int FC_N_OUT    = 10;
   localparam int FC_W_ADDR_W = clog2_min1(FC_N_IN * FC_N_OUT);
   localparam int FC_B_ADDR_W = clog2_min1(FC_N_OUT);

   function automatic logic signed [63:0] sat_to_w(input logic signed [63:0] acc, input int out_w);
      logic signed [63:0] hi;
      logic signed [63:0] lo;
      hi = (64'sd1 <<< (out_w - 1)) - 64'sd1;
      lo = -hi - 64'sd1;
      if (acc > hi) return hi;
      if (acc < lo) return lo;
      return acc;
   endfunction

endpackage

// File: rtl/fc_layer_stream_mac_unit.sv
// Signed multiply feeding a wrapping accumulator; acc_nxt is the value loaded on the next edge.
module fc_mac_unit #(
   parameter int IN_W  = 16,
   parameter int W_W   = 8,
   parameter int B_W   = 16,
   parameter int ACC_W = 32
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic                    clear,
   input  logic                    load_bias,
   input  logic                    acc_en,
   input  logic signed [IN_W-1:0]  act,
   input  logic signed [W_W-1:0]   weight,
   input  logic signed [B_W-1:0]   bias,
   output logic signed [ACC_W-1:0] acc_nxt
);

   localparam int P_W = IN_W + W_W;

   logic signed [P_W-1:0]   prod;
   logic signed [ACC_W-1:0] prod_ext;
   logic signed [ACC_W-1:0] bias_ext;
   logic signed [ACC_W-1:0] acc;

   assign prod     = P_W'(act) * P_W'(weight);
   assign prod_ext = ACC_W'(prod);
   assign bias_ext = ACC_W'(bias);

   always_comb begin
      acc_nxt = acc;
      if (clear)          acc_nxt = '0;
      else if (load_bias) acc_nxt = bias_ext + prod_ext;
      else if (acc_en)    acc_nxt = acc + prod_ext;
   end

   always_ff @(posedge clk) begin
      if (reset) acc <= '0;
      else       acc <= acc_nxt;
   end

endmodule

// File: rtl/fc_layer_stream.sv
// Streaming FC layer: buffer one activation vector, then one MAC per cycle per neuron.
// state | meaning
// IDLE  | waiting for start
// LOAD  | accepting N_IN activations into the buffer
// MAC   | issuing weight reads, accumulating previous cycle's product
// DRAIN | folding in the last product, registering the result
// OUT   | presenting one neuron result until accepted
// DONE  | one-cycle completion pulse
module fc_layer_stream
   import fc_pkg::*;
#(
   parameter int N_IN  = FC_N_IN,
   parameter int N_OUT = FC_N_OUT,
   parameter int IN_W  = 16,
   parameter int W_W   = 8,
   parameter int B_W   = 16,
   parameter int ACC_W = 32,
   parameter int OUT_W = 32,
   localparam int WA_W = clog2_min1(N_IN * N_OUT),
   localparam int BA_W = clog2_min1(N_OUT)
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic                    start,
   input  logic                    relu_en,
   output logic                    busy,
   input  logic                    in_valid,
   output logic                    in_ready,
   input  logic signed [IN_W-1:0]  in_data,
   output logic                    w_rd_en,
   output logic [WA_W-1:0]         w_addr,
   input  logic signed [W_W-1:0]   w_rdata,
   output logic                    b_rd_en,
   output logic [BA_W-1:0]         b_addr,
   input  logic signed [B_W-1:0]   b_rdata,
   output logic                    out_valid,
   input  logic                    out_ready,
   output logic signed [OUT_W-1:0] out_data,
   output logic [BA_W-1:0]         out_index,
   output logic                    done
);

   localparam int IDX_W = clog2_min1(N_IN);

   fc_state_e state, state_nxt;

   logic [IDX_W-1:0]        i_cnt;
   logic [IDX_W-1:0]        prev_i;
   logic [BA_W-1:0]         o_cnt;
   logic [WA_W-1:0]         w_base;
   logic                    relu_q;
   logic signed [IN_W-1:0]  act_buf [N_IN];
   logic                    last_i, last_o;
   logic                    load_bias, acc_en, acc_clear;
   logic signed [ACC_W-1:0] acc_nxt;
   logic signed [ACC_W-1:0] relu_val;

   assign last_i = (i_cnt == IDX_W'(N_IN - 1));
   assign last_o = (o_cnt == BA_W'(N_OUT - 1));

   always_ff @(posedge clk) begin
      if (reset) state <= IDLE;
      else       state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      busy      = 1'b0;
      in_ready  = 1'b0;
      w_rd_en   = 1'b0;
      w_addr    = '0;
      b_rd_en   = 1'b0;
      b_addr    = '0;
      out_valid = 1'b0;
      done      = 1'b0;
      load_bias = 1'b0;
      acc_en    = 1'b0;
      acc_clear = 1'b0;
      case (state)
         IDLE: begin
            acc_clear = 1'b1;
            if (start) state_nxt = LOAD;
         end
         LOAD: begin
            busy     = 1'b1;
            in_ready = 1'b1;
            if (in_valid && last_i) state_nxt = MAC;
         end
         MAC: begin
            busy    = 1'b1;
            w_rd_en = 1'b1;
            w_addr  = w_base + WA_W'(i_cnt);
            // Read data lags by a cycle: k=0 fetches bias, k=1 seeds acc with it.
            if (i_cnt == '0) begin
               b_rd_en = 1'b1;
               b_addr  = o_cnt;
            end
            load_bias = (i_cnt == IDX_W'(1));
            acc_en    = (i_cnt != '0);
            if (last_i) state_nxt = DRAIN;
         end
         DRAIN: begin
            busy      = 1'b1;
            acc_en    = 1'b1;
            state_nxt = OUT;
         end
         OUT: begin
            busy      = 1'b1;
            out_valid = 1'b1;
            if (out_ready) state_nxt = last_o ? DONE : MAC;
         end
         DONE: begin
            done      = 1'b1;
            state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_comb begin
      relu_val = acc_nxt;
      if (relu_q && acc_nxt[ACC_W-1]) relu_val = '0;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         i_cnt     <= '0;
         prev_i    <= '0;
         o_cnt     <= '0;
         w_base    <= '0;
         relu_q    <= 1'b0;
         out_data  <= '0;
         out_index <= '0;
      end else begin
         prev_i <= i_cnt;
         case (state)
            IDLE: begin
               if (start) begin
                  relu_q <= relu_en;
                  i_cnt  <= '0;
               end
            end
            LOAD: begin
               if (in_valid) begin
                  i_cnt <= last_i ? '0 : i_cnt + 1'b1;
                  if (last_i) begin
                     o_cnt  <= '0;
                     w_base <= '0;
                  end
               end
            end
            MAC: i_cnt <= last_i ? '0 : i_cnt + 1'b1;
            DRAIN: begin
               out_data  <= OUT_W'(sat_to_w(64'(relu_val), OUT_W));
               out_index <= o_cnt;
            end
            OUT: begin
               if (out_ready && !last_o) begin
                  o_cnt  <= o_cnt + 1'b1;
                  w_base <= w_base + WA_W'(N_IN);
               end
            end
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (state == LOAD && in_valid) act_buf[i_cnt] <= in_data;
   end

   fc_mac_unit #(
      .IN_W (IN_W),
      .W_W  (W_W),
      .B_W  (B_W),
      .ACC_W(ACC_W)
   ) u_mac (
      .clk      (clk),
      .reset    (reset),
      .clear    (acc_clear),
      .load_bias(load_bias),
      .acc_en   (acc_en),
      .act      (act_buf[prev_i]),
      .weight   (w_rdata),
      .bias     (b_rdata),
      .acc_nxt  (acc_nxt)
   );

endmodule

// File: tb/tb_fc_layer_stream.sv
// Directed bench for fc_layer_stream with N_IN=4, N_OUT=2, OUT_W=16 and sync weight/bias memories.
module tb_fc_layer_stream;

   localparam int N_IN  = 4;
   localparam int N_OUT = 2;
   localparam int IN_W  = 16;
   localparam int W_W   = 8;
   localparam int B_W   = 16;
   localparam int ACC_W = 32;
   localparam int OUT_W = 16;
   localparam int WA_W  = 3;
   localparam int BA_W  = 1;

   logic                    clk = 1'b0;
   logic                    reset = 1'b1;
   logic                    start = 1'b0;
   logic                    relu_en = 1'b0;
   logic                    busy;
   logic                    in_valid = 1'b0;
   logic                    in_ready;
   logic signed [IN_W-1:0]  in_data = '0;
   logic                    w_rd_en;
   logic [WA_W-1:0]         w_addr;
   logic signed [W_W-1:0]   w_rdata = '0;
   logic                    b_rd_en;
   logic [BA_W-1:0]         b_addr;
   logic signed [B_W-1:0]   b_rdata = '0;
   logic                    out_valid;
   logic                    out_ready = 1'b1;
   logic signed [OUT_W-1:0] out_data;
   logic [BA_W-1:0]         out_index;
   logic                    done;

   fc_layer_stream #(
      .N_IN (N_IN), .N_OUT(N_OUT), .IN_W(IN_W), .W_W(W_W),
      .B_W  (B_W),  .ACC_W(ACC_W), .OUT_W(OUT_W)
   ) dut (
      .clk      (clk),
      .reset    (reset),
      .start    (start),
      .relu_en  (relu_en),
      .busy     (busy),
      .in_valid (in_valid),
      .in_ready (in_ready),
      .in_data  (in_data),
      .w_rd_en  (w_rd_en),
      .w_addr   (w_addr),
      .w_rdata  (w_rdata),
      .b_rd_en  (b_rd_en),
      .b_addr   (b_addr),
      .b_rdata  (b_rdata),
      .out_valid(out_valid),
      .out_ready(out_ready),
      .out_data (out_data),
      .out_index(out_index),
      .done     (done)
   );

   always #5 clk = ~clk;

   logic signed [W_W-1:0] w_mem [N_IN*N_OUT];
   logic signed [B_W-1:0] b_mem [N_OUT];
   int w_tab [N_IN*N_OUT];
   int b_tab [N_OUT];
   int act_tab [N_IN];

   always @(posedge clk) begin
      if (w_rd_en) w_rdata <= w_mem[w_addr];
      if (b_rd_en) b_rdata <= b_mem[b_addr];
   end

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   logic signed [OUT_W-1:0] q_data [$];
   int q_idx [$];
   int done_cnt = 0;
   int done_cyc = 0;
   int beat_cnt = 0;
   int first_beat_cyc = 0;

   always @(negedge clk) begin
      if (out_valid && out_ready) begin
         q_data.push_back(out_data);
         q_idx.push_back(int'(out_index));
      end
      if (done) begin
         done_cnt++;
         done_cyc = cyc;
      end
      if (in_valid && in_ready) begin
         if (beat_cnt == 0) first_beat_cyc = cyc;
         beat_cnt++;
      end
   end

   int total = 0;
   int bad = 0;

   task automatic check_val(input string tag, input longint got, input longint exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   task automatic apply_mem();
      for (int k = 0; k < N_IN*N_OUT; k++) w_mem[k] = W_W'(w_tab[k]);
      for (int k = 0; k < N_OUT; k++) b_mem[k] = B_W'(b_tab[k]);
   endtask

   task automatic run_vec(input logic relu, input bit gaps);
      q_data.delete();
      q_idx.delete();
      done_cnt = 0;
      beat_cnt = 0;
      @(posedge clk); #1;
      start   = 1'b1;
      relu_en = relu;
      @(posedge clk); #1;
      start   = 1'b0;
      relu_en = 1'b0;
      for (int k = 0; k < N_IN; k++) begin
         if (gaps) begin
            int g;
            g = $urandom_range(0, 2);
            repeat (g) begin
               in_valid = 1'b0;
               in_data  = IN_W'($urandom);
               @(posedge clk); #1;
            end
         end
         in_valid = 1'b1;
         in_data  = IN_W'(act_tab[k]);
         @(posedge clk); #1;
      end
      in_valid = 1'b0;
   endtask

   task automatic wait_done(input string tag);
      int n;
      n = 0;
      while (done_cnt == 0 && n < 200) begin
         @(posedge clk);
         n++;
      end
      #1;
      check_val({tag, "_done_pulses"}, done_cnt, 1);
      check_val({tag, "_busy_after"}, busy, 0);
   endtask

   task automatic check_results(input string tag, input longint e0, input longint e1);
      check_val({tag, "_n_results"}, q_data.size(), 2);
      if (q_data.size() == 2) begin
         check_val({tag, "_data0"}, q_data[0], e0);
         check_val({tag, "_index0"}, q_idx[0], 0);
         check_val({tag, "_data1"}, q_data[1], e1);
         check_val({tag, "_index1"}, q_idx[1], 1);
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
      $fatal(1);
   end

   initial begin
      int n;
      int unstable;
      logic signed [OUT_W-1:0] d0;
      logic [BA_W-1:0] i0;

      act_tab = '{1, 2, 3, 4};
      w_tab   = '{1, 1, 1, 1, -1, 0, 2, 1};
      b_tab   = '{10, -5};
      apply_mem();

      repeat (3) @(posedge clk);
      #1;
      check_val("reset_outputs",
                {busy, in_ready, w_rd_en, w_addr, b_rd_en, b_addr, out_valid, out_data, out_index, done}, 0);
      reset = 1'b0;

      // 1+2+3+4+10 = 20 ; -1+0+6+4-5 = 4
      run_vec(1'b0, 1'b0);
      wait_done("basic");
      check_results("basic", 20, 4);
      check_val("basic_run_cycles", done_cyc - first_beat_cyc + 1, 17);

      // 9-20 = -11 clipped by ReLU
      b_tab = '{10, -20};
      apply_mem();
      run_vec(1'b1, 1'b0);
      wait_done("relu");
      check_results("relu", 20, 0);

      b_tab = '{10, -5};
      apply_mem();
      beat_cnt = 0;
      @(posedge clk); #1;
      in_valid = 1'b1;
      in_data  = 16'sd99;
      repeat (3) @(posedge clk);
      #1;
      check_val("idle_beats_consumed", beat_cnt, 0);
      check_val("idle_in_ready", in_ready, 0);
      in_valid = 1'b0;

      run_vec(1'b0, 1'b1);
      wait_done("gaps");
      check_results("gaps", 20, 4);
      check_val("gaps_beats", beat_cnt, N_IN);

      // 4*32767*127 saturates; neuron 1 lands exactly on the limits
      act_tab = '{32767, 32767, 32767, 32767};
      w_tab   = '{127, 127, 127, 127, 1, 0, 0, 0};
      b_tab   = '{0, 0};
      apply_mem();
      run_vec(1'b0, 1'b0);
      wait_done("sat_pos");
      check_results("sat_pos", 32767, 32767);

      w_tab = '{-127, -127, -127, -127, -1, 0, 0, 0};
      b_tab = '{0, -1};
      apply_mem();
      run_vec(1'b0, 1'b0);
      wait_done("sat_neg");
      check_results("sat_neg", -32768, -32768);

      act_tab = '{1, 2, 3, 4};
      w_tab   = '{1, 1, 1, 1, -1, 0, 2, 1};
      b_tab   = '{10, -5};
      apply_mem();
      out_ready = 1'b0;
      run_vec(1'b0, 1'b0);
      n = 0;
      while (!out_valid && n < 50) begin
         @(negedge clk);
         n++;
      end
      check_val("stall_out_valid", out_valid, 1);
      d0 = out_data;
      i0 = out_index;
      unstable = 0;
      repeat (5) begin
         @(negedge clk);
         if (!out_valid || out_data !== d0 || out_index !== i0 || w_rd_en || done) unstable++;
      end
      check_val("stall_unstable_cycles", unstable, 0);
      check_val("stall_held_data", d0, 20);
      @(posedge clk); #1;
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check_val("stall_one_transfer", q_data.size(), 1);
      check_val("stall_back_in_mac", out_valid, 0);
      out_ready = 1'b1;
      wait_done("stall");
      check_results("stall", 20, 4);

      run_vec(1'b0, 1'b0);
      n = 0;
      while (q_data.size() < 1 && n < 100) begin
         @(posedge clk);
         n++;
      end
      @(posedge clk); #1;
      check_val("abort_in_mac", w_rd_en, 1);
      reset = 1'b1;
      @(posedge clk); #1;
      check_val("abort_outputs",
                {busy, in_ready, w_rd_en, w_addr, b_rd_en, b_addr, out_valid, out_data, out_index, done}, 0);
      reset = 1'b0;
      repeat (4) @(posedge clk);
      #1;
      check_val("abort_no_done", done_cnt, 0);
      check_val("abort_idle", busy, 0);
      run_vec(1'b0, 1'b0);
      wait_done("after_abort");
      check_results("after_abort", 20, 4);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
